// File: rtl/cabine_elevador_if.sv
// Motor command / cabin status bundle between the elevator controller and the cabin model.
interface cabine_elevador_if;
  logic       motor_liga;
  logic       motor_direcao;
  logic [2:0] andar_atual;
  logic       entre_andares;
  logic       porta_aberta;
  logic       chegada;
  logic       falha;
  logic [1:0] falha_codigo;

  modport master (
    output motor_liga, motor_direcao,
    input  andar_atual, entre_andares, porta_aberta, chegada, falha, falha_codigo
  );

  modport slave (
    input  motor_liga, motor_direcao,
    output andar_atual, entre_andares, porta_aberta, chegada, falha, falha_codigo
  );
endinterface

// File: rtl/cabine_elevador.sv
// Cabin/shaft plant: turns motor commands into floor position, door dwell and latched faults.
// All outputs registered; motor commands act on the next rising edge, and are ignored while the door is open.
module cabine_elevador #(
  parameter int NUM_ANDARES     = 5,
  parameter int TICKS_POR_ANDAR = 8,
  parameter int TICKS_PORTA     = 4
) (
  input  logic             clock,
  input  logic             reset,
  cabine_elevador_if.slave cab
);
  localparam int              CW    = $clog2(TICKS_POR_ANDAR + 1);
  localparam int              PW    = $clog2(TICKS_PORTA + 1);
  localparam logic [CW-1:0]   C_ULT = CW'(TICKS_POR_ANDAR - 1);
  localparam logic [PW-1:0]   P_INI = PW'(TICKS_PORTA);
  localparam logic [2:0]      TOPO  = 3'(NUM_ANDARES - 1);

  typedef enum logic [2:0] {PARADO, MOVENDO, ESPERA, PORTA, FALHA} estado_t;

  estado_t       estado_q, estado_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] c_q, c_d;
  logic [PW-1:0] porta_cnt_q, porta_cnt_d;
  logic [2:0]    andar_q, andar_d;
  logic          porta_q, porta_d;
  logic          entre_q;
  logic          upd_q, upd_d;
  logic          chegada_q;
  logic          falha_q, falha_d;
  logic [1:0]    codigo_q, codigo_d;

  function automatic logic no_limite(input logic d, input logic [2:0] a);
    return d ? (a == TOPO) : (a == 3'd0);
  endfunction

  always_comb begin
    estado_d    = estado_q;
    dir_d       = dir_q;
    c_d         = c_q;
    porta_cnt_d = porta_cnt_q;
    andar_d     = andar_q;
    porta_d     = porta_q;
    upd_d       = 1'b0;
    falha_d     = falha_q;
    codigo_d    = codigo_q;

    case (estado_q)
      PARADO, MOVENDO, ESPERA: begin
        if (cab.motor_liga) begin
          // At a floor the direction may change freely, but leaving the shaft is a limit fault.
          if (c_q == '0) begin
            dir_d = cab.motor_direcao;
            if (no_limite(cab.motor_direcao, andar_q)) begin
              estado_d = FALHA;
              falha_d  = 1'b1;
              codigo_d = 2'b01;
            end else begin
              estado_d = MOVENDO;
              c_d      = CW'(1);
            end
          end else if (cab.motor_direcao != dir_q) begin
            estado_d = FALHA;
            falha_d  = 1'b1;
            codigo_d = 2'b10;
          end else begin
            estado_d = MOVENDO;
            if (c_q == C_ULT) begin
              if (no_limite(dir_q, andar_q)) begin
                estado_d = FALHA;
                falha_d  = 1'b1;
                codigo_d = 2'b01;
              end else begin
                c_d     = '0;
                upd_d   = 1'b1;
                andar_d = dir_q ? andar_q + 3'd1 : andar_q - 3'd1;
              end
            end else begin
              c_d = c_q + CW'(1);
            end
          end
        end else if (estado_q == MOVENDO) begin
          if (c_q == '0) begin
            estado_d    = PORTA;
            porta_cnt_d = P_INI;
            porta_d     = 1'b1;
          end else begin
            estado_d = ESPERA;
          end
        end
      end
      PORTA: begin
        porta_cnt_d = porta_cnt_q - PW'(1);
        if (porta_cnt_q == PW'(1)) begin
          porta_d  = 1'b0;
          estado_d = PARADO;
        end
      end
      FALHA: begin
        porta_d = 1'b0;
      end
      default: begin
        estado_d = PARADO;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= PARADO;
      dir_q       <= 1'b0;
      c_q         <= '0;
      porta_cnt_q <= '0;
      andar_q     <= 3'd0;
      porta_q     <= 1'b0;
      entre_q     <= 1'b0;
      upd_q       <= 1'b0;
      chegada_q   <= 1'b0;
      falha_q     <= 1'b0;
      codigo_q    <= 2'b00;
    end else begin
      estado_q    <= estado_d;
      dir_q       <= dir_d;
      c_q         <= c_d;
      porta_cnt_q <= porta_cnt_d;
      andar_q     <= andar_d;
      porta_q     <= porta_d;
      entre_q     <= (c_d != '0);
      upd_q       <= upd_d;
      chegada_q   <= upd_q;
      falha_q     <= falha_d;
      codigo_q    <= codigo_d;
    end
  end

  assign cab.andar_atual   = andar_q;
  assign cab.entre_andares = entre_q;
  assign cab.porta_aberta  = porta_q;
  assign cab.chegada       = chegada_q;
  assign cab.falha         = falha_q;
  assign cab.falha_codigo  = codigo_q;
endmodule

// File: tb/tb_cabine_elevador.sv
// Bench for cabine_elevador: directed table, corner sequences, then random commands against a tick-position model.
module tb_cabine_elevador;
  localparam int N = 5;
  localparam int T = 8;
  localparam int P = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cabine_elevador_if cab_if();

  cabine_elevador #(.NUM_ANDARES(N), .TICKS_POR_ANDAR(T), .TICKS_PORTA(P)) dut (
    .clock (clock),
    .reset (reset),
    .cab   (cab_if.slave)
  );

  always #5 clock = ~clock;

  // Reference: position in ticks along the shaft, plus door countdown and fault code.
  int m_pos, m_floor, m_dir, m_door, m_code;
  bit m_moved, m_arr, m_cheg;

  task automatic model_reset();
    m_pos = 0; m_floor = 0; m_dir = 1; m_door = 0; m_code = 0;
    m_moved = 0; m_arr = 0; m_cheg = 0;
  endtask

  task automatic model_step(input bit liga, input bit d);
    bit arrived;
    int nd, tgt;
    arrived = 0;
    m_cheg = m_arr;
    if (m_code != 0) begin
    end else if (m_door > 0) begin
      m_door--;
    end else if (liga) begin
      nd = d ? 1 : -1;
      if (m_pos % T == 0) begin
        tgt = m_pos / T + nd;
        if (tgt < 0 || tgt >= N) m_code = 1;
        else begin m_dir = nd; m_pos += nd; m_moved = 1; end
      end else if (nd != m_dir) begin
        m_code = 2;
      end else begin
        m_pos += m_dir;
        if (m_pos % T == 0) begin m_floor = m_pos / T; arrived = 1; end
      end
    end else if (m_pos % T == 0 && m_moved) begin
      m_door = P; m_moved = 0;
    end
    m_arr = arrived;
  endtask

  task automatic chk(input string nome, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nome, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int a, input int e, input int p,
                         input int c, input int f, input int cd);
    chk({tag, " andar"},   int'(cab_if.andar_atual),   a);
    chk({tag, " entre"},   int'(cab_if.entre_andares), e);
    chk({tag, " porta"},   int'(cab_if.porta_aberta),  p);
    chk({tag, " chegada"}, int'(cab_if.chegada),       c);
    chk({tag, " falha"},   int'(cab_if.falha),         f);
    chk({tag, " codigo"},  int'(cab_if.falha_codigo),  cd);
  endtask

  task automatic apply(input bit liga, input bit d);
    cab_if.motor_liga    = liga;
    cab_if.motor_direcao = d;
    @(posedge clock);
    model_step(liga, d);
    #1;
  endtask

  task automatic do_reset();
    cab_if.motor_liga    = 1'b0;
    cab_if.motor_direcao = 1'b0;
    reset = 1'b1;
    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run(input int n, input bit liga, input bit d);
    for (int i = 0; i < n; i++) apply(liga, d);
  endtask

  typedef struct {
    bit liga; bit dir;
    int andar; int entre; int porta; int cheg; int falha; int cod;
  } vec_t;

  vec_t tab[14];

  initial begin
    bit liga, cur_dir;
    int len;

    for (int i = 0; i < 7; i++) tab[i] = '{1, 1, 0, 1, 0, 0, 0, 0};
    tab[7]  = '{1, 1, 1, 0, 0, 0, 0, 0};
    tab[8]  = '{0, 0, 1, 0, 1, 1, 0, 0};
    tab[9]  = '{0, 0, 1, 0, 1, 0, 0, 0};
    tab[10] = '{0, 0, 1, 0, 1, 0, 0, 0};
    tab[11] = '{0, 0, 1, 0, 1, 0, 0, 0};
    tab[12] = '{0, 0, 1, 0, 0, 0, 0, 0};
    tab[13] = '{0, 0, 1, 0, 0, 0, 0, 0};

    model_reset();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      apply(tab[i].liga, tab[i].dir);
      chk_all($sformatf("tab%0d", i), tab[i].andar, tab[i].entre, tab[i].porta,
              tab[i].cheg, tab[i].falha, tab[i].cod);
    end

    // Up two floors, door cycle, then back down one.
    do_reset();
    run(16, 1, 1);
    chk("up2 andar", int'(cab_if.andar_atual), 2);
    run(5, 0, 0);
    chk("up2 porta closed", int'(cab_if.porta_aberta), 0);
    run(7, 1, 0);
    chk("down mid andar", int'(cab_if.andar_atual), 2);
    chk("down mid entre", int'(cab_if.entre_andares), 1);
    apply(1, 0);
    chk_all("down1", 1, 0, 0, 0, 0, 0);

    // Limit faults at both ends of the shaft.
    do_reset();
    apply(1, 0);
    chk_all("lim bottom", 0, 0, 0, 0, 1, 1);
    do_reset();
    run(32, 1, 1);
    chk("top andar", int'(cab_if.andar_atual), 4);
    apply(1, 1);
    chk_all("lim top", 4, 0, 0, 1, 1, 1);
    apply(0, 0);
    chk_all("lim top hold", 4, 0, 0, 0, 1, 1);

    // Pause between floors: no door, counting resumes.
    do_reset();
    run(3, 1, 1);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0);
      chk_all($sformatf("pause%0d", i), 0, 1, 0, 0, 0, 0);
    end
    run(4, 1, 1);
    chk("resume mid andar", int'(cab_if.andar_atual), 0);
    apply(1, 1);
    chk_all("resume arrive", 1, 0, 0, 0, 0, 0);

    // Reversal between floors, then asynchronous reset.
    do_reset();
    run(3, 1, 1);
    apply(1, 0);
    chk_all("reverse", 0, 1, 0, 0, 1, 2);
    apply(1, 1);
    apply(0, 0);
    chk_all("reverse hold", 0, 1, 0, 0, 1, 2);
    do_reset();

    // Motor held on through the door window.
    run(8, 1, 1);
    apply(0, 0);
    chk_all("door open", 1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(1, 1);
      chk_all($sformatf("interlock%0d", i), 1, 0, 1, 0, 0, 0);
    end
    apply(1, 1);
    chk_all("door closed", 1, 0, 0, 0, 0, 0);
    run(7, 1, 1);
    chk_all("post door mid", 1, 1, 0, 0, 0, 0);
    apply(1, 1);
    chk_all("post door arrive", 2, 0, 0, 0, 0, 0);

    // Random command bursts checked every cycle against the model.
    do_reset();
    cur_dir = 1;
    for (int seg = 0; seg < 300; seg++) begin
      liga = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) cur_dir = ~cur_dir;
      len = $urandom_range(1, 12);
      if (m_code != 0 && $urandom_range(0, 2) == 0) do_reset();
      for (int k = 0; k < len; k++) begin
        apply(liga, cur_dir);
        chk_all("rand", m_floor, int'(m_pos % T != 0), int'(m_door > 0),
                int'(m_cheg), int'(m_code != 0), m_code);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cabine_elevador.md
Name: cabine_elevador

Overview:
Cabin/shaft model that sits at the other end of the elevator controller's motor interface. It consumes motor_liga/motor_direcao and produces the floor-sensor value andar_atual that the controller reads, closing the control loop. It is used both as the plant model in system benches and as the position tracker on the FPGA board. It also models travel time between floors, door dwell after arrival, and latched mechanical faults.

Parameters:
NUM_ANDARES, 5, number of floors; floors are 0..NUM_ANDARES-1, with NUM_ANDARES <= 8.
TICKS_POR_ANDAR, 8, clock cycles of motor-on travel between adjacent floors; must be >= 2.
TICKS_PORTA, 4, clock cycles the door stays open after a stop at a floor; must be >= 1.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; returns the cabin to floor 0, idle
motor_liga  input  1  motor enable from the controller
motor_direcao  input  1  1 = up, 0 = down; sampled only while motor_liga=1
andar_atual  output  3  last floor reached; drives the controller's floor input
entre_andares  output  1  1 while the cabin is away from a floor (progress counter != 0)
porta_aberta  output  1  door open
chegada  output  1  one-cycle pulse in the cycle after andar_atual updates
falha  output  1  latched fault; cleared only by reset
falha_codigo  output  2  00 none, 01 end-of-travel (limit), 10 reversal between floors

Behaviour:
- Reset values: andar_atual=0, entre_andares=0, porta_aberta=0, chegada=0, falha=0, falha_codigo=00. Internal state is PARADO, progress counter c=0, door timer=0.
- All outputs are registered. Inputs are sampled on the rising clock edge.
- States:
  - PARADO: cabin at rest.
  - MOVENDO: motor on, cabin travelling.
  - ESPERA: motor off with the cabin between floors.
  - PORTA: door open.
  - FALHA: fault latched.
- PARADO:
  - If motor_liga=1, latch dir=motor_direcao.
  - Limit check first: if dir=1 and andar_atual=NUM_ANDARES-1, or dir=0 and andar_atual=0, go to FALHA with code 01.
  - Otherwise go to MOVENDO and set c=1 on the same edge.
- MOVENDO, motor_liga=1 and motor_direcao=dir:
  - c increments by 1 each edge.
  - When c reaches TICKS_POR_ANDAR, c becomes 0 and andar_atual becomes andar_atual+1 (dir=1) or andar_atual-1 (dir=0) on the same edge.
  - Result: with the motor held on, andar_atual changes exactly TICKS_POR_ANDAR edges after the first motor-on edge.
- MOVENDO, motor_liga=1 with motor_direcao != dir:
  - If c=0 (at a floor), re-latch dir, apply the limit check, continue.
  - If c!=0, go to FALHA with code 10.
- MOVENDO, motor_liga=0:
  - If c=0, go to PORTA with door timer = TICKS_PORTA and porta_aberta=1 on that edge.
  - If c!=0, go to ESPERA; c is held and no door opens.
- ESPERA:
  - motor_liga=1 with the same dir: resume MOVENDO, counting continues from the held c.
  - motor_liga=1 with the opposite dir: FALHA, code 10.
- PORTA:
  - Door timer decrements each edge.
  - motor_liga is ignored (door interlock); no position change.
  - When the timer reaches 0, porta_aberta=0 and the state becomes PARADO; a motor command is sampled from the next edge on.
- FALHA:
  - falha=1 and falha_codigo hold until reset.
  - Position is frozen and porta_aberta=0.
  - Further faults do not overwrite the code.
- Outputs:
  - entre_andares = (c != 0), registered with c.
  - chegada=1 for exactly one cycle, following each andar_atual update.
- andar_atual never leaves 0..NUM_ANDARES-1; any computed out-of-range value is a limit fault instead.
- Reset asserted mid-travel or with the door open: immediate return to the reset values.

Test Plan:
- Defaults (T=8, P=4), start at floor 0; hold motor_liga=1, motor_direcao=1 for 8 edges, then drop it -> andar_atual 0→1 on edge 8; chegada pulses on edge 9; entre_andares=1 on edges 1-7; porta_aberta=1 for 4 cycles, then 0.
- From floor 0, run up for 16 edges -> andar_atual=2; drop the motor; after the door closes, run down for 8 edges -> andar_atual=1; no fault.
- At floor 0, motor_liga=1, motor_direcao=0 -> falha=1, falha_codigo=01 on the next edge; andar_atual stays 0. At floor 4 with direction up -> falha_codigo=01.
- Run up 3 edges, motor_liga=0 for 5 cycles, then up again for 5 edges -> entre_andares stays 1 during the pause, no door opens, andar_atual=1 after 8 total motor-on edges.
- Run up 3 edges, then motor_direcao=0 with motor_liga=1 -> falha_codigo=10, position frozen; assert reset -> all outputs return to reset values with andar_atual=0.
- Motor on during the door-open window at floor 1 -> ignored until the door closes; movement starts the edge after PARADO is reached; andar_atual=2 eight edges later.
